// File: rtl/led_breathe.sv
// PWM LED driver with a triangular "breathing" brightness ramp.
// A free-running PWM counter sets the duty window, and a 5-state FSM steps the duty level.
module led_breathe #(
  parameter int PWM_BITS     = 8,
  parameter int STEP_PERIODS = 4,
  parameter int HOLD_PERIODS = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic [2:0]          phase
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } phase_e;

  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_PERIODS - 1);

  phase_e              phase_q, phase_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [SW-1:0]       step_q, step_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                led_q, led_d;
  logic                period_end;

  assign period_end = enable && (pwm_q == MAX);

  // Next-state: PWM counter, duty ramp FSM and LED compare.
  always_comb begin
    phase_d = phase_q;
    level_d = level_q;
    pwm_d   = pwm_q;
    step_d  = step_q;
    hold_d  = hold_q;
    led_d   = (phase_q != IDLE) && (pwm_q < level_q);
    if (!enable) begin
      phase_d = IDLE;
      level_d = '0;
      pwm_d   = '0;
      step_d  = '0;
      hold_d  = '0;
      led_d   = 1'b0;
    end else begin
      pwm_d = pwm_q + 1'b1;
      case (phase_q)
        IDLE: begin
          phase_d = RISE;
          pwm_d   = '0;
          level_d = '0;
          step_d  = '0;
          hold_d  = '0;
        end
        RISE: begin
          if (period_end) begin
            if (step_q == STEP_LAST) begin
              step_d = '0;
              if (level_q != MAX) begin
                level_d = level_q + 1'b1;
                if (level_q == MAX - 1'b1) begin
                  phase_d = HOLD_HI;
                  hold_d  = '0;
                end
              end
            end else begin
              step_d = step_q + 1'b1;
            end
          end
        end
        HOLD_HI: begin
          level_d = MAX;
          if (period_end) begin
            if (hold_q == HOLD_LAST) begin
              phase_d = FALL;
              hold_d  = '0;
              step_d  = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        FALL: begin
          if (period_end) begin
            if (step_q == STEP_LAST) begin
              step_d = '0;
              if (level_q != '0) begin
                level_d = level_q - 1'b1;
                if (level_q == PWM_BITS'(1)) begin
                  phase_d = HOLD_LO;
                  hold_d  = '0;
                end
              end
            end else begin
              step_d = step_q + 1'b1;
            end
          end
        end
        HOLD_LO: begin
          level_d = '0;
          if (period_end) begin
            if (hold_q == HOLD_LAST) begin
              phase_d = RISE;
              hold_d  = '0;
              step_d  = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: begin
          phase_d = IDLE;
          level_d = '0;
          pwm_d   = '0;
          step_d  = '0;
          hold_d  = '0;
          led_d   = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= IDLE;
      level_q <= '0;
      pwm_q   <= '0;
      step_q  <= '0;
      hold_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      level_q <= level_d;
      pwm_q   <= pwm_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      led_q   <= led_d;
    end
  end

  assign led   = led_q;
  assign level = level_q;
  assign phase = phase_q;

endmodule
